wide_add_seq: RTL

- Multi-precision add/subtract sequencer.
- Accepts WORDS*N-bit operands over a valid/ready handshake.
- Processes one N-bit word per cycle through a single carry-lookahead word slice, least-significant word first.
- Holds the carry in a register between words, then presents the full-width result on an output handshake.
- Used wherever wide arithmetic must share one narrow lookahead adder instead of instantiating a full-width adder.

---
 rtl/wide_add_seq_pkg.sv | 13 +
 rtl/wide_add_seq_if.sv | 41 ++++
 rtl/wide_add_seq_cla_word.sv | 40 ++++
 rtl/wide_add_seq.sv | 133 +++++++++++++
 4 files changed

// File: rtl/wide_add_seq_pkg.sv
// Shared types and defaults for the wide_add_seq multi-precision add/subtract sequencer.
package wide_add_seq_pkg;

  localparam int unsigned DefaultN     = 8;
  localparam int unsigned DefaultWords = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/wide_add_seq_if.sv
// Operand and result handshakes of wide_add_seq.
// Optional overflow output is present when WIDE_ADD_SEQ_OVF_EN is defined.
interface wide_add_seq_if
  import wide_add_seq_pkg::*;
#(
  parameter int unsigned N     = DefaultN,
  parameter int unsigned WORDS = DefaultWords
);
  localparam int unsigned W = N * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;
`ifdef WIDE_ADD_SEQ_OVF_EN
  logic         ovf;
`endif

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
`ifdef WIDE_ADD_SEQ_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, s, cout
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
`ifdef WIDE_ADD_SEQ_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, s, cout
  );

endinterface

// File: rtl/wide_add_seq_cla_word.sv
// N-bit generate/propagate carry-lookahead word slice; also exposes the carry into the MSB.
module wide_add_seq_cla_word #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] s_o,
  output logic         cout_o,
  output logic         c_msb_o
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;

  // Each carry is the flat sum-of-products of lower generates, not a ripple chain.
  always_comb begin
    logic pp;
    pp   = 1'b0;
    g    = a_i & b_i;
    p    = a_i ^ b_i;
    c    = '0;
    c[0] = cin_i;
    for (int i = 0; i < int'(N); i++) begin
      c[i+1] = g[i];
      pp     = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp     = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & cin_i);
    end
  end

  assign s_o     = p ^ c[N-1:0];
  assign cout_o  = c[N];
  assign c_msb_o = c[N-1];

endmodule

// File: rtl/wide_add_seq.sv
// Multi-precision add/subtract sequencer: one lookahead word slice reused LSW first.
// Define WIDE_ADD_SEQ_OVF_EN to add the signed-overflow output.
module wide_add_seq
  import wide_add_seq_pkg::*;
#(
  parameter int unsigned N     = DefaultN,
  parameter int unsigned WORDS = DefaultWords
) (
  input  logic          clk,
  input  logic          rst,
  wide_add_seq_if.slave bus
);

  localparam int unsigned W  = N * WORDS;
  localparam int unsigned KW = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    s_q, s_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic [31:0]     base;
  logic [N-1:0]    word_s;
  logic            word_cout;
  logic            word_cmsb;
  logic            last_word;

  assign base      = 32'(k_q) * N;
  assign last_word = (k_q == KW'(WORDS - 1));

  wide_add_seq_cla_word #(
    .N (N)
  ) u_slice (
    .a_i     (a_q[base +: N]),
    .b_i     (b_q[base +: N]),
    .cin_i   (carry_q),
    .s_o     (word_s),
    .cout_o  (word_cout),
    .c_msb_o (word_cmsb)
  );

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    s_d         = s_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid && in_ready_q) begin
          a_d        = bus.a;
          // Subtraction becomes A + ~B + 1 by inverting B and the incoming borrow.
          b_d        = bus.sub ? ~bus.b : bus.b;
          carry_d    = bus.cin ^ bus.sub;
          k_d        = '0;
          in_ready_d = 1'b0;
          state_d    = StRun;
        end
      end
      StRun: begin
        s_d[base +: N] = word_s;
        carry_d        = word_cout;
        if (last_word) begin
          cout_d  = word_cout;
          ovf_d   = word_cmsb ^ word_cout;
          k_d     = '0;
          state_d = StDone;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StDone: begin
        out_valid_d = 1'b1;
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      k_q         <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      s_q         <= s_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.s         = s_q;
  assign bus.cout      = cout_q;

`ifdef WIDE_ADD_SEQ_OVF_EN
  assign bus.ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ^{ovf_q, word_cmsb};
`endif

endmodule
